// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned WL_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 65;
  localparam int unsigned LENW_DEF  = 4;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef logic owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned WL   = dmem_arb_pkg::WL_DEF,
  parameter int unsigned LENW = dmem_arb_pkg::LENW_DEF
);
  logic            req0, req1;
  logic            we0, we1;
  logic [WL-1:0]   addr0, addr1;
  logic [LENW-1:0] len0, len1;
  logic [WL-1:0]   wdata0, wdata1;
  logic            ack0, ack1;
  logic            done0, done1;
  logic [WL-1:0]   rdata0, rdata1;
  logic            err;
  logic            mem_write_EN;
  logic [WL-1:0]   mem_addr;
  logic [WL-1:0]   mem_writeData;
  logic [WL-1:0]   mem_readData;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
           mem_readData,
    output ack0, ack1, done0, done1, rdata0, rdata1, err,
           mem_write_EN, mem_addr, mem_writeData
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
           mem_readData,
    input  ack0, ack1, done0, done1, rdata0, rdata1, err,
           mem_write_EN, mem_addr, mem_writeData
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: the requester that did not own last wins ties.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    valid = req0 | req1;
    grant = 1'b0;
    if (req0 && req1) grant = ~last;
    else if (req1)    grant = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and burst sequencer for the single-ported data_mem.
// Optional address bounds check enabled by DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WL    = WL_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LENW  = LENW_DEF
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("dmem_arbiter: DEPTH must be at least 1");
  end

  state_t          state, state_nxt;
  owner_t          owner_q, last_q, grant;
  logic            pick_valid, load, active, oob;
  logic            we_q;
  logic [WL-1:0]   base_q, addr_cur;
  logic [LENW-1:0] len_q, beat_q;

  rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (last_q),
    .grant (grant),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (pick_valid) begin
        state_nxt = BURST;
        load      = 1'b1;
      end
      BURST: if (beat_q == len_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else if (load) begin
      owner_q <= grant;
      last_q  <= grant;
      we_q    <= grant ? bus.we1   : bus.we0;
      base_q  <= grant ? bus.addr1 : bus.addr0;
      len_q   <= grant ? bus.len1  : bus.len0;
      beat_q  <= '0;
    end else if (state == BURST) begin
      beat_q  <= beat_q + LENW'(1);
    end
  end

  assign addr_cur = base_q + WL'(beat_q);
  // RST gates the burst outputs so an aborted beat never reaches memory.
  assign active   = (state == BURST) && !RST;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  assign oob = active && (addr_cur >= WL'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    bus.ack0          = 1'b0;
    bus.ack1          = 1'b0;
    bus.done0         = 1'b0;
    bus.done1         = 1'b0;
    bus.rdata0        = '0;
    bus.rdata1        = '0;
    bus.err           = 1'b0;
    bus.mem_write_EN  = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_writeData = '0;
    if (active) begin
      bus.mem_addr      = addr_cur;
      bus.mem_write_EN  = we_q && !oob;
      bus.mem_writeData = owner_q ? bus.wdata1 : bus.wdata0;
      bus.err           = oob;
      if (owner_q) begin
        bus.ack1   = 1'b1;
        bus.done1  = (beat_q == len_q);
        bus.rdata1 = oob ? '0 : bus.mem_readData;
      end else begin
        bus.ack0   = 1'b1;
        bus.done0  = (beat_q == len_q);
        bus.rdata0 = oob ? '0 : bus.mem_readData;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural data_mem.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif
  localparam int unsigned DEPTH = 65;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        err;
  } beat_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;
  beat_t q[$];
  logic [31:0] mem [0:127] = '{default: '0};

  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.WL(32), .LENW(4)) bus ();

  dmem_arbiter #(.WL(32), .DEPTH(DEPTH), .LENW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.mem_readData = (bus.mem_addr < 32'd128) ? mem[bus.mem_addr[6:0]] : 32'h0;

  always @(posedge CLK)
    if (bus.mem_write_EN && bus.mem_addr < 32'd128)
      mem[bus.mem_addr[6:0]] <= bus.mem_writeData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},   {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err}, 0);
    check({tag, "_we"},    bus.mem_write_EN, 0);
    check({tag, "_addr"},  bus.mem_addr, 0);
    check({tag, "_wd"},    bus.mem_writeData, 0);
    check({tag, "_rd"},    bus.rdata0 | bus.rdata1, 0);
  endtask

  task automatic push_burst(input logic port, input logic we, input logic [31:0] addr,
                            input logic [3:0] len, input logic [31:0] d0);
    beat_t e;
    if (port) begin bus.we1 = we; bus.addr1 = addr; bus.len1 = len; end
    else      begin bus.we0 = we; bus.addr0 = addr; bus.len0 = len; end
    for (int unsigned i = 0; i <= len; i++) begin
      e.port = port;
      e.we   = we;
      e.addr = addr + i;
      e.data = d0 + i;
      e.done = (i == len);
      e.err  = BCHK && (e.addr >= DEPTH);
      q.push_back(e);
    end
  endtask

  task automatic drive_wdata();
    if (q.size() > 0) begin
      if (q[0].port) begin bus.wdata1 = q[0].data; bus.wdata0 = ~q[0].data; end
      else           begin bus.wdata0 = q[0].data; bus.wdata1 = ~q[0].data; end
    end
  endtask

  task automatic monitor();
    beat_t e;
    logic  p;
    if (prev_done) check("bubble", {bus.ack0, bus.ack1}, 0);
    if (bus.ack0 || bus.ack1) begin
      if (q.size() == 0) begin
        check("unexpected_ack", {bus.ack0, bus.ack1}, 0);
      end else begin
        e = q.pop_front();
        p = bus.ack1;
        check("both_ack",    bus.ack0 & bus.ack1, 0);
        check("owner",       p, e.port);
        check("done",        p ? bus.done1 : bus.done0, e.done);
        check("other_done",  p ? bus.done0 : bus.done1, 0);
        check("mem_addr",    bus.mem_addr, e.addr);
        check("write_en",    bus.mem_write_EN, e.we & ~e.err);
        check("err",         bus.err, e.err);
        if (e.we) check("wdata", bus.mem_writeData, e.data);
        else      check("rdata", p ? bus.rdata1 : bus.rdata0, e.err ? 32'h0 : e.data);
        check("other_rdata", p ? bus.rdata0 : bus.rdata1, 0);
      end
    end else begin
      check("idle_we",   bus.mem_write_EN, 0);
      check("idle_addr", bus.mem_addr, 0);
      check("idle_done", {bus.done0, bus.done1, bus.err}, 0);
    end
    prev_done = bus.done0 | bus.done1;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    drive_wdata();
    @(negedge CLK);
    monitor();
  endtask

  task automatic run_until_empty(input int unsigned max);
    for (int unsigned i = 0; i < max; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    check("timeout_pending", q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero("in_reset");
    RST = 1'b0;
    @(negedge CLK);
    check_zero("after_reset");
    prev_done = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    do_reset();

    // Single write: words 5..7, first beat one cycle after the grant edge.
    push_burst(1'b0, 1'b1, 32'd5, 4'd2, 32'hA);
    drive_wdata();
    bus.req0 = 1'b1;
    #1 check("latency_idle", bus.ack0, 0);
    cycle();
    check("latency_first", bus.ack0, 1);
    bus.req0 = 1'b0;
    run_until_empty(10);
    cycle();
    check("mem5", mem[5], 32'hA);
    check("mem6", mem[6], 32'hB);
    check("mem7", mem[7], 32'hC);

    // Read-back on port 1.
    push_burst(1'b1, 1'b0, 32'd5, 4'd2, 32'hA);
    bus.req1 = 1'b1;
    cycle();
    bus.req1 = 1'b0;
    run_until_empty(10);
    cycle();

    // Contention after reset: port 0 first, then strict alternation.
    do_reset();
    bus.we0 = 0; bus.addr0 = 32'd5; bus.len0 = '0;
    bus.we1 = 0; bus.addr1 = 32'd6; bus.len1 = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      push_burst(1'b0, 1'b0, 32'd5, 4'd0, 32'hA);
      push_burst(1'b1, 1'b0, 32'd6, 4'd0, 32'hB);
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    run_until_empty(20);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) cycle();

    // Requester drops req after the first ack; burst still runs 4 beats.
    push_burst(1'b0, 1'b1, 32'd20, 4'd3, 32'h20);
    bus.req0 = 1'b1;
    cycle();
    bus.req0 = 1'b0;
    run_until_empty(10);
    cycle();
    check("mem23", mem[23], 32'h23);

    // Reset during the second beat of a 4-beat write to word 10.
    push_burst(1'b0, 1'b1, 32'd10, 4'd3, 32'h100);
    bus.req0 = 1'b1;
    cycle();
    bus.req0 = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_zero("rst_beat2");
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_zero("post_rst");
    q.delete();
    prev_done = 1'b0;
    repeat (2) cycle();
    check("mem10", mem[10], 32'h100);
    check("mem11", mem[11], 32'h0);

    // Burst crossing the end of memory.
    push_burst(1'b1, 1'b1, 32'd63, 4'd2, 32'h630);
    bus.req1 = 1'b1;
    cycle();
    bus.req1 = 1'b0;
    run_until_empty(10);
    cycle();
    check("mem63", mem[63], 32'h630);
    check("mem64", mem[64], 32'h631);
    check("mem65", mem[65], BCHK ? 32'h0 : 32'h632);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
